flit_demux: RTL

Registered, handshaked 1-to-N flit demultiplexer for the NoC router output stage. Generalises the fixed 1-to-5 combinational demux to a parametrised width and port count, adds valid/ready flow control, a one-cycle output register and wormhole packet locking. A packet's destination is sampled from the head flit and held until the tail flit is accepted. Flits addressed to a non-existent port are consumed and dropped with an error pulse.

---
 rtl/noc_pkg.sv | 6 +
 rtl/flit_demux_ctrl.sv | 48 ++++
 rtl/flit_demux.sv | 63 ++++++
 3 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: shared NoC router types and default flit/port sizing
package noc_pkg;
  typedef enum logic [1:0] {IDLE, LOCK, DROP} demux_state_t;
  localparam int FLIT_W = 32;
  localparam int N_PORTS = 5;
endpackage

// File: rtl/flit_demux_ctrl.sv
// flit_demux_ctrl: wormhole lock/drop state machine; err_cnt exists only with FLIT_DEMUX_ERR_CNT_EN
module flit_demux_ctrl import noc_pkg::*; #(
  parameter int N_OUT = N_PORTS,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             room,
  output logic             in_ready,
  output logic             load,
  output logic             drop,
  output logic [SEL_W-1:0] dest_eff
`ifdef FLIT_DEMUX_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);
  demux_state_t state, state_nxt;
  logic [SEL_W-1:0] lock_sel;
  logic acc, sel_ok;
  always_comb begin
    sel_ok = {1'b0, in_sel} < (SEL_W+1)'(N_OUT);
    in_ready = state == DROP ? 1'b1 : room;
    acc = in_valid && in_ready;
    dest_eff = state == LOCK ? lock_sel : in_sel;
    load = acc && (state == LOCK || (state == IDLE && sel_ok));
    drop = acc && state == IDLE && !sel_ok;
    state_nxt = !acc ? state : in_last ? IDLE : state != IDLE ? state : sel_ok ? LOCK : DROP;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lock_sel <= '0;
    end else begin
      state <= state_nxt;
      if (load && state == IDLE && !in_last) lock_sel <= in_sel;
    end
  end
`ifdef FLIT_DEMUX_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt <= '0;
    else err_cnt <= err_cnt + 16'(drop && err_cnt != 16'hFFFF);
  end
`endif
endmodule

// File: rtl/flit_demux.sv
// flit_demux: registered handshaked 1-to-N wormhole flit demux; optional err_cnt via FLIT_DEMUX_ERR_CNT_EN
module flit_demux import noc_pkg::*; #(
  parameter int WIDTH = FLIT_W,
  parameter int N_OUT = N_PORTS,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [SEL_W-1:0] in_sel,
  output logic [N_OUT-1:0] out_valid,
  input  logic [N_OUT-1:0] out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             err_drop
`ifdef FLIT_DEMUX_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);
  logic full, load, drop, hs;
  logic [SEL_W-1:0] dest, dest_eff;
  for (genvar i = 0; i < N_OUT; i++) begin : g_dec
    assign out_valid[i] = full && dest == SEL_W'(i);
  end
  assign hs = |(out_valid & out_ready);
  flit_demux_ctrl #(.N_OUT(N_OUT), .SEL_W(SEL_W)) u_ctrl (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_sel(in_sel),
    .room(!full || hs),
    .in_ready(in_ready),
    .load(load),
    .drop(drop),
    .dest_eff(dest_eff)
`ifdef FLIT_DEMUX_ERR_CNT_EN
    ,
    .err_cnt(err_cnt)
`endif
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dest <= '0;
      out_data <= '0;
      out_last <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      err_drop <= drop;
      if (load) begin
        full <= 1'b1;
        dest <= dest_eff;
        out_data <= in_data;
        out_last <= in_last;
      end else if (hs) full <= 1'b0;
    end
  end
endmodule
